// File: rtl/timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_irq_ctrl
//
// Memory-mapped timer and interrupt controller for the single-cycle CPU. It
// sits on the data-memory bus next to DataMem and decodes a 16-word window
// at BASE. It provides:
//   - a reloading cycle counter (TL) with reload value TH,
//   - an interrupt status bit that is latched on overflow,
//   - a free-running system tick counter.
//
// Register map (byte offsets from BASE; unused offsets read 0, ignore writes):
//   +0x00 TH      reload value, R/W
//   +0x04 TL      counter, R/W
//   +0x08 TCON    [0] EN, [1] IE, [2] ST (ST is cleared by writing 0 and
//                 cannot be set by software); [31:3] read 0
//   +0x0C SYSTICK free-running cycle count, read-only
//
// Ports:
//   clk     in   system clock, rising-edge active
//   reset   in   asynchronous, active-high reset
//   rd      in   bus read strobe (MemRd)
//   wr      in   bus write strobe (MemWr)
//   addr    in   byte address, decoded on [31:2]
//   wdata   in   write data
//   rdata   out  read data; 0 when rd is low or the address is not decoded
//   kernel  in   PC[31]; masks irq while the CPU runs in kernel space
//   irq     out  interrupt request = ST & IE & ~kernel
//
// Bus protocol: there is no valid/ready handshake. A strobe qualifies the
// access for exactly the cycle it is high, and every access completes in that
// cycle. Writes commit on the rising edge. Reads are combinational and return
// the pre-edge register contents, including when rd and wr are both high.
// -----------------------------------------------------------------------------
module timer_irq_ctrl #(
    parameter logic [31:0] BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        kernel,
    output logic        irq
);

    localparam logic [3:0] OFF_TH   = 4'd0;
    localparam logic [3:0] OFF_TL   = 4'd1;
    localparam logic [3:0] OFF_TCON = 4'd2;
    localparam logic [3:0] OFF_TICK = 4'd3;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [31:0] tick_q, tick_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;

    logic        in_win;
    logic [3:0]  off;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        overflow;

    // The byte lane bits carry no information for word registers.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    // The 16-word window spans 64 bytes, so bits [31:6] select the window and
    // bits [5:2] select the word inside it.
    assign in_win  = (addr[31:6] == BASE[31:6]);
    assign off     = addr[5:2];
    assign wr_th   = wr && in_win && (off == OFF_TH);
    assign wr_tl   = wr && in_win && (off == OFF_TL);
    assign wr_tcon = wr && in_win && (off == OFF_TCON);

    assign overflow = en_q && (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        en_d   = en_q;
        ie_d   = ie_q;
        st_d   = st_q;
        tick_d = tick_q + 32'd1;

        if (wr_th) begin
            th_d = wdata;
        end

        // A software write to TL beats both the reload and the increment.
        // The reload uses the pre-edge TH.
        if (wr_tl) begin
            tl_d = wdata;
        end else if (overflow) begin
            tl_d = th_q;
        end else if (en_q) begin
            tl_d = tl_q + 32'd1;
        end

        if (wr_tcon) begin
            en_d = wdata[0];
            ie_d = wdata[1];
            if (!wdata[2]) begin
                st_d = 1'b0;
            end
        end

        // This comes after the clear, so a coincident overflow is not lost.
        // The pre-edge IE gates it, whatever the TCON write puts in IE.
        if (overflow && ie_q) begin
            st_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tick_q <= 32'd0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            st_q   <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tick_q <= tick_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            st_q   <= st_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (rd && in_win) begin
            case (off)
                OFF_TH:   rdata = th_q;
                OFF_TL:   rdata = tl_q;
                OFF_TCON: rdata = {29'd0, st_q, ie_q, en_q};
                OFF_TICK: rdata = tick_q;
                default:  rdata = 32'd0;
            endcase
        end
    end

    assign irq = st_q && ie_q && !kernel;

endmodule
